// File: rtl/gshare_pht_pkg.sv
// Shared fetch-unit types for the gshare direction predictor: widths, PHT
// counter encoding, update record and FSM states.
package gshare_pht_pkg;

  localparam int unsigned ADDR_WIDTH      = 32;
  localparam int unsigned PHT_INDEX_WIDTH = 8;
  localparam int unsigned PC_ALIGN_BITS   = 2;

  typedef logic [PHT_INDEX_WIDTH-1:0] PHTIndex;
  typedef logic [PHT_INDEX_WIDTH-1:0] GlobalBranchHistory;
  typedef logic [1:0]                 PHTCounter;

  localparam PHTCounter PHT_COUNTER_INIT = 2'b01;

  typedef struct packed {
    logic               valid;
    PHTIndex            phtIndex;
    logic               taken;
    logic               mispredict;
    GlobalBranchHistory ghrSnapshot;
  } PHTUpdate;

  typedef enum logic {
    PHT_INIT,
    PHT_READY
  } pht_state_e;

  function automatic PHTCounter pht_sat_step(input PHTCounter c, input logic taken);
    if (taken) return (c == 2'b11) ? c : PHTCounter'(c + 2'b01);
    else       return (c == 2'b00) ? c : PHTCounter'(c - 2'b01);
  endfunction

endpackage

// File: rtl/pht_counter_ram.sv
// PHT storage: unreset array of 2-bit counters, one async read port and one
// write port that muxes the init clear over saturating training writes.
module pht_counter_ram
  import gshare_pht_pkg::*;
#(
  parameter int unsigned INDEX_WIDTH = PHT_INDEX_WIDTH
) (
  input  logic                   clk,
  input  logic [INDEX_WIDTH-1:0] i_rdIdx,
  output PHTCounter              o_rdData,
  input  logic                   i_clrEn,
  input  logic [INDEX_WIDTH-1:0] i_clrIdx,
  input  logic                   i_trainEn,
  input  logic [INDEX_WIDTH-1:0] i_trainIdx,
  input  logic                   i_trainTaken
);

  localparam int unsigned DEPTH = 2 ** INDEX_WIDTH;

  PHTCounter              r_mem [DEPTH];
  logic                   w_we;
  logic [INDEX_WIDTH-1:0] w_wrIdx;
  PHTCounter              w_wrData;

  always_comb begin
    w_we     = 1'b0;
    w_wrIdx  = '0;
    w_wrData = PHT_COUNTER_INIT;
    if (i_clrEn) begin
      w_we     = 1'b1;
      w_wrIdx  = i_clrIdx;
      w_wrData = PHT_COUNTER_INIT;
    end else if (i_trainEn) begin
      w_we     = 1'b1;
      w_wrIdx  = i_trainIdx;
      w_wrData = pht_sat_step(r_mem[i_trainIdx], i_trainTaken);
    end
  end

  always_ff @(posedge clk) begin
    if (w_we) r_mem[w_wrIdx] <= w_wrData;
  end

  assign o_rdData = r_mem[i_rdIdx];

endmodule

// File: rtl/gshare_pht.sv
// Gshare direction predictor: PC/GHR hash, speculative global history with
// misprediction repair, and the PHT clear sweep after reset.
module gshare_pht
  import gshare_pht_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH      = gshare_pht_pkg::ADDR_WIDTH,
  parameter int unsigned PHT_INDEX_WIDTH = gshare_pht_pkg::PHT_INDEX_WIDTH,
  parameter int unsigned PC_ALIGN_BITS   = gshare_pht_pkg::PC_ALIGN_BITS
) (
  input  logic                       clk,
  input  logic                       rst_n,
  output logic                       initDone,
  input  logic                       lookupValid,
  input  logic                       lookupIsBranch,
  input  logic [ADDR_WIDTH-1:0]      lookupPc,
  output logic [PHT_INDEX_WIDTH-1:0] phtIndex,
  output logic                       isBranchTakenPredicted,
  output logic [PHT_INDEX_WIDTH-1:0] ghrSnapshot,
  input  logic                       updateValid,
  input  logic [PHT_INDEX_WIDTH-1:0] updatePhtIndex,
  input  logic                       updateTaken,
  input  logic                       updateMispredict,
  input  logic [PHT_INDEX_WIDTH-1:0] updateGhrSnapshot
);

  localparam int unsigned IW = PHT_INDEX_WIDTH;

  if (IW < 2) begin : g_bad_index_width
    $error("gshare_pht: PHT_INDEX_WIDTH must be at least 2");
  end
  if (ADDR_WIDTH <= IW + PC_ALIGN_BITS) begin : g_bad_addr_width
    $error("gshare_pht: ADDR_WIDTH too small for the PHT hash");
  end

  pht_state_e    r_state;
  pht_state_e    w_stateNext;
  logic [IW-1:0] r_clrPtr;
  logic [IW-1:0] r_ghr;
  logic [IW-1:0] w_ghrNext;
  logic [IW-1:0] w_phtIndex;
  logic          w_ready;
  logic          w_clrEn;
  logic          w_train;
  logic          w_pred;
  PHTCounter     w_rdData;
  logic          w_unusedBits;

  assign w_ready    = (r_state == PHT_READY);
  assign w_phtIndex = lookupPc[IW+PC_ALIGN_BITS-1:PC_ALIGN_BITS] ^ r_ghr;
  assign w_pred     = w_ready & w_rdData[1];
  assign w_train    = w_ready & updateValid;

  assign w_unusedBits = ^{lookupPc[ADDR_WIDTH-1:IW+PC_ALIGN_BITS],
                          lookupPc[PC_ALIGN_BITS-1:0], updateGhrSnapshot[IW-1]};

  always_comb begin
    w_stateNext = r_state;
    w_clrEn     = 1'b0;
    unique case (r_state)
      PHT_INIT: begin
        w_clrEn = 1'b1;
        if (r_clrPtr == '1) w_stateNext = PHT_READY;
      end
      PHT_READY: w_stateNext = PHT_READY;
      default:   w_stateNext = PHT_INIT;
    endcase
  end

  // Repair of a resolved misprediction overrides this cycle's speculative shift.
  always_comb begin
    w_ghrNext = r_ghr;
    if (w_ready) begin
      if (updateValid && updateMispredict)
        w_ghrNext = {updateGhrSnapshot[IW-2:0], updateTaken};
      else if (lookupValid && lookupIsBranch)
        w_ghrNext = {r_ghr[IW-2:0], w_pred};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= PHT_INIT;
      r_clrPtr <= '0;
      r_ghr    <= '0;
    end else begin
      r_state <= w_stateNext;
      r_ghr   <= w_ghrNext;
      if (w_clrEn) r_clrPtr <= r_clrPtr + 1'b1;
    end
  end

  pht_counter_ram #(
    .INDEX_WIDTH(IW)
  ) u_ram (
    .clk          (clk),
    .i_rdIdx      (w_phtIndex),
    .o_rdData     (w_rdData),
    .i_clrEn      (w_clrEn),
    .i_clrIdx     (r_clrPtr),
    .i_trainEn    (w_train),
    .i_trainIdx   (updatePhtIndex),
    .i_trainTaken (updateTaken)
  );

  assign initDone               = w_ready;
  assign phtIndex               = w_phtIndex;
  assign isBranchTakenPredicted = w_pred;
  assign ghrSnapshot            = r_ghr;

endmodule

// File: tb/tb_gshare_pht.sv
// Bench for gshare_pht: directed vector table plus randomized traffic checked
// against an array-based gshare model.
module tb_gshare_pht;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        initDone;
  logic        lookupValid;
  logic        lookupIsBranch;
  logic [31:0] lookupPc;
  logic [7:0]  phtIndex;
  logic        isBranchTakenPredicted;
  logic [7:0]  ghrSnapshot;
  logic        updateValid;
  logic [7:0]  updatePhtIndex;
  logic        updateTaken;
  logic        updateMispredict;
  logic [7:0]  updateGhrSnapshot;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  gshare_pht #(
    .ADDR_WIDTH     (32),
    .PHT_INDEX_WIDTH(8),
    .PC_ALIGN_BITS  (2)
  ) dut (
    .clk                    (clk),
    .rst_n                  (rst_n),
    .initDone               (initDone),
    .lookupValid            (lookupValid),
    .lookupIsBranch         (lookupIsBranch),
    .lookupPc               (lookupPc),
    .phtIndex               (phtIndex),
    .isBranchTakenPredicted (isBranchTakenPredicted),
    .ghrSnapshot            (ghrSnapshot),
    .updateValid            (updateValid),
    .updatePhtIndex         (updatePhtIndex),
    .updateTaken            (updateTaken),
    .updateMispredict       (updateMispredict),
    .updateGhrSnapshot      (updateGhrSnapshot)
  );

  // Reference model: counters as plain ints, history as an 8-bit int.
  int m_pht [256];
  int m_ghr;
  int m_cnt;
  bit m_ready;

  function automatic int m_idx();
    return int'((lookupPc >> 2) & 32'hFF) ^ m_ghr;
  endfunction

  function automatic int m_pred();
    return (m_ready && m_pht[m_idx()] >= 2) ? 1 : 0;
  endfunction

  task automatic model_reset();
    m_ghr = 0; m_cnt = 0; m_ready = 0;
  endtask

  task automatic model_edge();
    int p, i;
    if (!m_ready) begin
      m_cnt++;
      if (m_cnt == 256) begin
        m_ready = 1;
        foreach (m_pht[j]) m_pht[j] = 1;
      end
    end else begin
      p = m_pred();
      if (updateValid) begin
        i = int'(updatePhtIndex);
        if (updateTaken) m_pht[i] = (m_pht[i] == 3) ? 3 : m_pht[i] + 1;
        else             m_pht[i] = (m_pht[i] == 0) ? 0 : m_pht[i] - 1;
      end
      if (updateValid && updateMispredict)
        m_ghr = (int'(updateGhrSnapshot) * 2 + int'(updateTaken)) % 256;
      else if (lookupValid && lookupIsBranch)
        m_ghr = (m_ghr * 2 + p) % 256;
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_model();
    check("initDone", 32'(initDone), 32'(m_ready));
    check("phtIndex", 32'(phtIndex), 32'(m_idx()));
    check("predict", 32'(isBranchTakenPredicted), 32'(m_pred()));
    check("ghrSnapshot", 32'(ghrSnapshot), 32'(m_ghr));
  endtask

  task automatic set_in(input bit lv, input bit lb, input logic [31:0] pc, input bit uv,
                        input int ui, input bit ut, input bit um, input int us);
    lookupValid = lv; lookupIsBranch = lb; lookupPc = pc;
    updateValid = uv; updatePhtIndex = 8'(ui); updateTaken = ut;
    updateMispredict = um; updateGhrSnapshot = 8'(us);
  endtask

  task automatic set_random();
    set_in(1'($urandom), 1'($urandom), $urandom, 1'($urandom), int'($urandom_range(0, 255)),
           1'($urandom), ($urandom_range(0, 3) == 0), int'($urandom_range(0, 255)));
  endtask

  task automatic clk_step();
    @(posedge clk);
    if (rst_n) model_edge();
    @(negedge clk);
  endtask

  // Sweep phase: random inputs before the sweep ends, idle afterwards.
  task automatic run_sweep(input int n, input bit probe10);
    for (int k = 0; k < n; k++) begin
      if (k < 256) set_random();
      else set_in(0, 0, 32'h0, 0, 0, 0, 0, 0);
      if (probe10 && k == 10) set_in(1, 1, 32'h40, 1, 'h10, 1, 1, 'hAA);
      #1;
      check_model();
      check("initDone_sweep", 32'(initDone), 32'(k >= 256));
      clk_step();
    end
  endtask

  typedef struct {
    bit          lb;
    logic [31:0] pc;
    bit          uv;
    int          ui;
    bit          ut;
    bit          um;
    int          us;
    int          ePred;
    int          eIdx;
    int          eGhr;
  } vec_t;

  function automatic vec_t mk(input bit lb, input logic [31:0] pc, input bit uv, input int ui,
                              input bit ut, input bit um, input int us,
                              input int ePred, input int eIdx, input int eGhr);
    vec_t v;
    v.lb = lb; v.pc = pc; v.uv = uv; v.ui = ui; v.ut = ut; v.um = um; v.us = us;
    v.ePred = ePred; v.eIdx = eIdx; v.eGhr = eGhr;
    return v;
  endfunction

  vec_t tbl [21];

  initial begin
    // Training/saturation on 0x10 (counter 01 after the ignored cycle-10 update)
    tbl[0]  = mk(0, 32'h40, 1, 'h10, 1, 0, 0, 0, 'h10, 0);
    tbl[1]  = mk(0, 32'h40, 1, 'h10, 1, 0, 0, 1, 'h10, 0);
    tbl[2]  = mk(0, 32'h40, 1, 'h10, 1, 0, 0, 1, 'h10, 0);
    tbl[3]  = mk(0, 32'h40, 1, 'h10, 0, 0, 0, 1, 'h10, 0);
    tbl[4]  = mk(0, 32'h40, 1, 'h10, 0, 0, 0, 1, 'h10, 0);
    tbl[5]  = mk(0, 32'h40, 1, 'h10, 0, 0, 0, 0, 'h10, 0);
    tbl[6]  = mk(0, 32'h40, 1, 'h10, 0, 0, 0, 0, 'h10, 0);
    tbl[7]  = mk(0, 32'h40, 0, 0, 0, 0, 0, 0, 'h10, 0);
    tbl[8]  = mk(0, 32'h40, 1, 'h10, 1, 0, 0, 0, 'h10, 0);
    tbl[9]  = mk(0, 32'h40, 1, 'h10, 1, 0, 0, 0, 'h10, 0);
    tbl[10] = mk(0, 32'h40, 0, 0, 0, 0, 0, 1, 'h10, 0);
    // Speculative history: taken, not-taken, taken
    tbl[11] = mk(1, 32'h40, 0, 0, 0, 0, 0, 1, 'h10, 'h00);
    tbl[12] = mk(1, 32'h80, 0, 0, 0, 0, 0, 0, 'h21, 'h01);
    tbl[13] = mk(1, 32'h48, 0, 0, 0, 0, 0, 1, 'h10, 'h02);
    tbl[14] = mk(0, 32'h40, 0, 0, 0, 0, 0, 0, 'h15, 'h05);
    // Misprediction repair: force GHR to 0xFF, then repair with 0x3C during a branch lookup
    tbl[15] = mk(0, 32'h40, 1, 'h33, 1, 1, 'h7F, 0, 'h15, 'h05);
    tbl[16] = mk(1, 32'h40, 1, 'h44, 1, 1, 'h3C, 0, 'hEF, 'hFF);
    // Same-index collision on 0x50, then an invalid update that must be ignored
    tbl[17] = mk(0, 32'hA4, 1, 'h50, 1, 0, 0, 0, 'h50, 'h79);
    tbl[18] = mk(0, 32'hA4, 0, 0, 0, 0, 0, 1, 'h50, 'h79);
    tbl[19] = mk(0, 32'hA4, 0, 'h50, 0, 1, 0, 1, 'h50, 'h79);
    tbl[20] = mk(0, 32'hA4, 0, 0, 0, 0, 0, 1, 'h50, 'h79);

    rst_n = 1'b0;
    set_in(0, 0, 32'h0, 0, 0, 0, 0, 0);
    model_reset();
    @(negedge clk);
    set_in(1, 1, 32'h1234, 0, 0, 0, 0, 0);
    #1;
    check_model();
    check("reset_initDone", 32'(initDone), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    run_sweep(257, 1'b1);

    foreach (tbl[r]) begin
      set_in(1, tbl[r].lb, tbl[r].pc, tbl[r].uv, tbl[r].ui, tbl[r].ut, tbl[r].um, tbl[r].us);
      #1;
      check($sformatf("vec%0d_pred", r), 32'(isBranchTakenPredicted), 32'(tbl[r].ePred));
      check($sformatf("vec%0d_idx", r), 32'(phtIndex), 32'(tbl[r].eIdx));
      check($sformatf("vec%0d_ghr", r), 32'(ghrSnapshot), 32'(tbl[r].eGhr));
      check_model();
      clk_step();
    end

    for (int k = 0; k < 2000; k++) begin
      set_random();
      #1;
      check_model();
      clk_step();
    end

    // Reset while READY takes effect without waiting for a clock edge
    set_in(1, 0, 32'h40, 0, 0, 0, 0, 0);
    rst_n = 1'b0;
    #1;
    model_reset();
    check_model();
    check("rst_ready_initDone", 32'(initDone), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    run_sweep(100, 1'b0);

    set_in(1, 1, 32'h40, 0, 0, 0, 0, 0);
    rst_n = 1'b0;
    #1;
    model_reset();
    check_model();
    check("rst_mid_ghr", 32'(ghrSnapshot), 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    run_sweep(257, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/gshare_pht.md
Name: gshare_pht

Overview:
- Gshare direction predictor in the fetch stage.
- Directly upstream of the branch-predict generation logic: it supplies the PHT index and the taken/not-taken prediction for the instruction being fetched.
- Holds a 2-bit saturating-counter pattern history table (PHT) and a speculative global history register (GHR).
- Trained and repaired by the branch-resolution update port from execute.

Parameters:
ADDR_WIDTH, 32, PC width (taken from BasicTypes).
PHT_INDEX_WIDTH, 8, log2 of PHT entries (256). GHR width equals this value.
PC_ALIGN_BITS, 2, low PC bits dropped before hashing.

Ports:
clk  in  1  clock.
rst_n  in  1  asynchronous active-low reset.
initDone  out  1  high once the PHT clear sweep has finished.
lookupValid  in  1  fetch is consuming lookupPc this cycle.
lookupIsBranch  in  1  predecode marks the fetched instruction as a conditional branch.
lookupPc  in  ADDR_WIDTH  PC being fetched.
phtIndex  out  PHT_INDEX_WIDTH  hashed index for lookupPc.
isBranchTakenPredicted  out  1  MSB of the selected counter.
ghrSnapshot  out  PHT_INDEX_WIDTH  GHR value used for this lookup; carried down the pipeline.
updateValid  in  1  a branch resolved this cycle.
updatePhtIndex  in  PHT_INDEX_WIDTH  index recorded at prediction time.
updateTaken  in  1  actual outcome.
updateMispredict  in  1  direction was mispredicted.
updateGhrSnapshot  in  PHT_INDEX_WIDTH  GHR snapshot recorded at prediction time.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Values forced by reset:
  - FSM state = INIT; clear pointer = 0; GHR = 0.
  - initDone = 0.
  - isBranchTakenPredicted = 0.
- PHT storage:
  - RAM-style array with no reset of its own.
  - Contents are valid only after the INIT sweep.
- FSM states:
  - INIT: one entry written per cycle, to 2'b01 (weakly not-taken), at the clear pointer; pointer increments. When the entry 2^PHT_INDEX_WIDTH-1 is written, next state = READY. Sweep takes exactly 256 cycles from reset release (default).
  - READY: terminal. initDone = 1, registered.
- Reset asserted mid-sweep, or while READY: state returns to INIT and the pointer returns to 0; the sweep restarts from entry 0.
- Lookup (combinational, same cycle):
  - phtIndex = lookupPc[PHT_INDEX_WIDTH+PC_ALIGN_BITS-1 : PC_ALIGN_BITS] XOR GHR.
  - isBranchTakenPredicted = PHT[phtIndex][1] when READY, else 0.
  - ghrSnapshot = current GHR.
- Speculative GHR update:
  - Condition: READY && lookupValid && lookupIsBranch.
  - Action: GHR <= {GHR[W-2:0], isBranchTakenPredicted}.
- Counter training:
  - Condition: READY && updateValid.
  - Entry at updatePhtIndex: saturating +1 if updateTaken, else saturating -1.
  - 2'b11 stays 2'b11 on taken; 2'b00 stays 2'b00 on not-taken.
- GHR repair:
  - Condition: READY && updateValid && updateMispredict.
  - Action: GHR <= {updateGhrSnapshot[W-2:0], updateTaken}.
  - Takes priority over the speculative update in the same cycle.
- Simultaneous lookup and update to the same index: the lookup returns the pre-update value (read-before-write); the new value is visible on the next cycle.
- Updates arriving during INIT are dropped: no counter write, no GHR change.
- Update with updateValid = 0 has no effect regardless of the other update inputs.
- PHT_INDEX_WIDTH >= 2 is required; width mismatches are elaboration errors.

Decomposition:
- Add to FetchUnitTypes:
  - PHT_INDEX_WIDTH and PC_ALIGN_BITS constants.
  - PHTIndex and GlobalBranchHistory typedefs.
  - PHTCounter typedef (2 bits) and a PHT_COUNTER_INIT = 2'b01 constant.
  - PHTUpdate struct {valid, phtIndex, taken, mispredict, ghrSnapshot}.
- One natural sub-module: pht_counter_ram. It holds the array, with one asynchronous read port and one write port. Its write mux selects INIT-clear over training writes.
- GHR, FSM and hash logic live in gshare_pht.

Test Plan:
- Init sweep:
  - Stimulus: release rst_n; run 256 cycles.
  - Required: initDone is 0 through cycle 255 and 1 at cycle 256.
  - Required: lookups of any PC return taken = 0, including during INIT.
  - Required: an update at cycle 10 is ignored (a later probe reads 2'b01).
- Training and saturation:
  - Stimulus: GHR = 0; two taken updates at index 0x10.
  - Required: lookupPc 0x40 predicts taken.
  - Stimulus: a third taken update, then four not-taken updates.
  - Required: counter stays 2'b11, then walks down to 2'b00; predicts not-taken from the second not-taken onward.
- Speculative history:
  - Stimulus: three consecutive branch lookups predicted taken, not-taken, taken.
  - Required: GHR = 8'b0000_0101.
  - Required: phtIndex for PC 0x40 = 0x10 ^ 0x05 = 0x15.
- Misprediction repair:
  - Stimulus: GHR = 0xFF; update with mispredict = 1, snapshot 0x3C, taken = 1, in the same cycle as a branch lookup.
  - Required: next-cycle GHR = 0x79 (repair wins over the speculative shift).
- Same-index collision:
  - Stimulus: counter at 2'b01; lookup and taken update on the same index in the same cycle.
  - Required: lookup shows not-taken; the same lookup next cycle shows taken (2'b10).
- Reset mid-operation:
  - Stimulus: assert rst_n low at sweep cycle 100, then release.
  - Required: initDone drops immediately, GHR = 0, and the full 256-cycle sweep repeats.
